// File: rtl/obi_lsu.sv
// OBI load/store unit: issues MEM-stage accesses on an OBI data port,
// tracks in-flight requests in an ordered tag FIFO and aligns load data.
module obi_lsu #(
    parameter int WIDTH           = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int REG_WIDTH       = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [REG_WIDTH-1:0]  rd_i,
    input  logic                  flush_i,
    output logic                  resp_valid_o,
    output logic                  resp_we_o,
    output logic [REG_WIDTH-1:0]  resp_rd_o,
    output logic [WIDTH-1:0]      resp_rdata_o,
    output logic                  misaligned_o,
    output logic                  proto_err_o,
    output logic                  busy_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [WIDTH/8-1:0]    obi_be_o,
    output logic [WIDTH-1:0]      obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [WIDTH-1:0]      obi_rdata_i
);

    localparam int BEW = WIDTH / 8;
    localparam int OFF = $clog2(BEW);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic                 we;
        logic [REG_WIDTH-1:0] rd;
        logic [OFF-1:0]       off;
        logic [1:0]           size;
        logic                 uns;
        logic                 kill;
    } tag_t;

    logic                  a_pending_q, a_pending_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic                  a_we_q, a_we_d;
    logic [BEW-1:0]        a_be_q, a_be_d;
    logic [WIDTH-1:0]      a_wdata_q, a_wdata_d;
    tag_t                  a_tag_q, a_tag_d;

    tag_t                  fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_we_q, resp_we_d;
    logic [REG_WIDTH-1:0]  resp_rd_q, resp_rd_d;
    logic [WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
    logic                  mis_q, mis_d;
    logic                  perr_q, perr_d;

    logic [OFF-1:0]        off;
    logic                  mis;
    logic [BEW-1:0]        be_mask;
    logic                  hs, hs_ok, gnt, pop;
    tag_t                  head, push_tag;
    logic [WIDTH-1:0]      sh, ld;

    assign off         = addr_i[OFF-1:0];
    assign req_ready_o = !a_pending_q && (count_q < CW'(MAX_OUTSTANDING));
    assign hs          = req_valid_i && req_ready_o;
    assign hs_ok       = hs && !mis;
    assign gnt         = a_pending_q && obi_gnt_i;
    assign pop         = obi_rvalid_i && (count_q != '0);
    assign head        = fifo_q[rptr_q];

    always_comb begin
        mis     = 1'b0;
        be_mask = BEW'(1);
        case (size_i)
            2'b01: begin
                mis     = off[0];
                be_mask = BEW'(3);
            end
            2'b10: begin
                mis     = |off[1:0];
                be_mask = BEW'(15);
            end
            2'b11: begin
                mis     = (WIDTH == 32) || (|off);
                be_mask = '1;
            end
            default: ;
        endcase
    end

    // Offset and size travel with the tag so the response can be realigned.
    always_comb begin
        sh = obi_rdata_i >> {head.off, 3'b000};
        case (head.size)
            2'b00:   ld = head.uns ? WIDTH'(sh[7:0])
                                   : WIDTH'($signed(sh[7:0]));
            2'b01:   ld = head.uns ? WIDTH'(sh[15:0])
                                   : WIDTH'($signed(sh[15:0]));
            2'b10:   ld = head.uns ? WIDTH'(sh[31:0])
                                   : WIDTH'($signed(sh[31:0]));
            default: ld = sh;
        endcase
    end

    always_comb begin
        a_pending_d = a_pending_q;
        a_addr_d    = a_addr_q;
        a_we_d      = a_we_q;
        a_be_d      = a_be_q;
        a_wdata_d   = a_wdata_q;
        a_tag_d     = a_tag_q;
        if (flush_i) a_tag_d.kill = 1'b1;
        if (gnt) a_pending_d = 1'b0;
        if (hs_ok) begin
            a_pending_d = 1'b1;
            a_addr_d    = {addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            a_we_d      = we_i;
            a_be_d      = be_mask << off;
            a_wdata_d   = wdata_i << {off, 3'b000};
            a_tag_d     = '{we: we_i, rd: rd_i, off: off, size: size_i,
                            uns: unsigned_i, kill: flush_i};
        end
    end

    always_comb begin
        push_tag      = a_tag_q;
        push_tag.kill = a_tag_q.kill | flush_i;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        if (gnt)
            wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)
            rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
        count_d = count_q + CW'(gnt) - CW'(pop);
    end

    always_comb begin
        resp_valid_d = pop && !head.kill;
        resp_we_d    = resp_we_q;
        resp_rd_d    = resp_rd_q;
        resp_rdata_d = resp_rdata_q;
        if (pop) begin
            resp_we_d    = head.we;
            resp_rd_d    = head.rd;
            resp_rdata_d = head.we ? '0 : ld;
        end
        mis_d  = hs && mis;
        perr_d = perr_q || (obi_rvalid_i && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_pending_q  <= 1'b0;
            a_addr_q     <= '0;
            a_we_q       <= 1'b0;
            a_be_q       <= '0;
            a_wdata_q    <= '0;
            a_tag_q      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_rd_q    <= '0;
            resp_rdata_q <= '0;
            mis_q        <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            a_pending_q  <= a_pending_d;
            a_addr_q     <= a_addr_d;
            a_we_q       <= a_we_d;
            a_be_q       <= a_be_d;
            a_wdata_q    <= a_wdata_d;
            a_tag_q      <= a_tag_d;
            // Killed entries still drain through OBI; only the response is muted.
            if (flush_i)
                for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i].kill <= 1'b1;
            if (gnt) fifo_q[wptr_q] <= push_tag;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_we_q    <= resp_we_d;
            resp_rd_q    <= resp_rd_d;
            resp_rdata_q <= resp_rdata_d;
            mis_q        <= mis_d;
            perr_q       <= perr_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_we_o    = resp_we_q;
    assign resp_rd_o    = resp_rd_q;
    assign resp_rdata_o = resp_rdata_q;
    assign misaligned_o = mis_q;
    assign proto_err_o  = perr_q;
    assign busy_o       = a_pending_q || (count_q != '0);
    assign obi_req_o    = a_pending_q;
    assign obi_addr_o   = a_addr_q;
    assign obi_we_o     = a_we_q;
    assign obi_be_o     = a_be_q;
    assign obi_wdata_o  = a_wdata_q;

endmodule

// File: tb/tb_obi_lsu.sv
// Scoreboard bench for obi_lsu: a queue-based model of accepted, granted
// and retired accesses predicts OBI A-phase outputs and load/store responses.
module tb_obi_lsu;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = '0;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        resp_valid_o;
    logic        resp_we_o;
    logic [4:0]  resp_rd_o;
    logic [31:0] resp_rdata_o;
    logic        misaligned_o;
    logic        proto_err_o;
    logic        busy_o;
    logic        obi_req_o;
    logic        obi_gnt_i = 1'b0;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;

    always #5 clk = ~clk;

    obi_lsu #(
        .WIDTH(32), .ADDR_WIDTH(32), .REG_WIDTH(5), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .we_i(we_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o),
        .resp_rd_o(resp_rd_o), .resp_rdata_o(resp_rdata_o),
        .misaligned_o(misaligned_o), .proto_err_o(proto_err_o),
        .busy_o(busy_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
        .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
        .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
    );

    typedef struct {
        bit        we;
        bit [4:0]  rd;
        bit [1:0]  sz;
        bit        uns;
        bit [1:0]  off;
        bit        kill;
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
    } txn_t;

    typedef struct {
        bit        we;
        bit [4:0]  rd;
        bit [31:0] data;
        int        due;
    } rsp_t;

    txn_t apend[$];
    txn_t outst[$];
    rsp_t exp_q[$];
    bit   mis_exp;
    bit   perr;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic bit [31:0] exp_load(input bit [31:0] rdata,
                                           input bit [1:0] off,
                                           input bit [1:0] sz,
                                           input bit uns);
        longint unsigned v, mask;
        int bits;
        bits = 8 << sz;
        mask = (64'd1 << bits) - 64'd1;
        v = (64'(rdata) >> (8 * off)) & mask;
        if (!uns && (((v >> (bits - 1)) & 64'd1) != 0)) v = v | ~mask;
        return 32'(v);
    endfunction

    function automatic bit [3:0] exp_be(input bit [1:0] sz,
                                        input bit [1:0] off);
        bit [3:0] b;
        b = '0;
        for (int i = 0; i < 4; i++)
            b[i] = (i >= int'(off)) && (i < int'(off) + (1 << sz));
        return b;
    endfunction

    task automatic do_cycle(input bit rv, input bit we, input bit [1:0] sz,
                            input bit uns, input bit [31:0] addr,
                            input bit [31:0] wd, input bit [4:0] rd,
                            input bit fl, input bit g, input bit rvl,
                            input bit [31:0] rdat);
        bit   rdy;
        bit   mis;
        txn_t t;
        rsp_t r;
        rdy = (apend.size() == 0) && (outst.size() < MAXO);
        chk("req_ready", req_ready_o, rdy);
        chk("obi_req", obi_req_o, apend.size() != 0);
        chk("busy", busy_o, (apend.size() != 0) || (outst.size() != 0));
        chk("misaligned", misaligned_o, mis_exp);
        chk("proto_err", proto_err_o, perr);
        if (apend.size() != 0) begin
            chk("obi_addr", obi_addr_o, apend[0].addr);
            chk("obi_we", obi_we_o, apend[0].we);
            chk("obi_be", obi_be_o, apend[0].be);
            chk("obi_wdata", obi_wdata_o, apend[0].wdata);
        end
        req_valid_i  = rv;
        we_i         = we;
        size_i       = sz;
        unsigned_i   = uns;
        addr_i       = addr;
        wdata_i      = wd;
        rd_i         = rd;
        flush_i      = fl;
        obi_gnt_i    = g;
        obi_rvalid_i = rvl;
        obi_rdata_i  = rdat;
        mis_exp = 1'b0;
        if (rvl) begin
            if (outst.size() == 0) perr = 1'b1;
            else begin
                t = outst.pop_front();
                if (!t.kill) begin
                    r.we   = t.we;
                    r.rd   = t.rd;
                    r.data = t.we ? 32'h0 : exp_load(rdat, t.off, t.sz, t.uns);
                    r.due  = cyc + 1;
                    exp_q.push_back(r);
                end
            end
        end
        if (g && apend.size() != 0) outst.push_back(apend.pop_front());
        if (rv && rdy) begin
            mis = (sz == 2'd3) || ((addr % (32'd1 << sz)) != 0);
            if (mis) mis_exp = 1'b1;
            else begin
                t.we    = we;
                t.rd    = rd;
                t.sz    = sz;
                t.uns   = uns;
                t.off   = addr[1:0];
                t.kill  = 1'b0;
                t.addr  = addr & ~32'h3;
                t.be    = exp_be(sz, addr[1:0]);
                t.wdata = 32'(64'(wd) << (8 * addr[1:0]));
                apend.push_back(t);
            end
        end
        if (fl) begin
            foreach (apend[i]) apend[i].kill = 1'b1;
            foreach (outst[i]) outst[i].kill = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wd,
                       input bit [4:0] rd);
        do_cycle(1, we, sz, uns, addr, wd, rd, 0, 0, 0, 0);
    endtask

    task automatic gnt();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic rv(input bit [31:0] d);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid_i = 0; flush_i = 0; obi_gnt_i = 0; obi_rvalid_i = 0;
        apend.delete();
        outst.delete();
        exp_q.delete();
        mis_exp = 1'b0;
        perr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_we", resp_we_o, 0);
        chk("rst_resp_rd", resp_rd_o, 0);
        chk("rst_resp_rdata", resp_rdata_o, 0);
        chk("rst_misaligned", misaligned_o, 0);
        chk("rst_proto_err", proto_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_obi_req", obi_req_o, 0);
        chk("rst_obi_addr", obi_addr_o, 0);
        chk("rst_obi_we", obi_we_o, 0);
        chk("rst_obi_be", obi_be_o, 0);
        chk("rst_obi_wdata", obi_wdata_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        rst = 1'b0;
    endtask

    // Response monitor: pairs each DUT response with the oldest prediction.
    initial begin
        rsp_t e;
        bit   due;
        forever begin
            @(negedge clk);
            due = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            chk("resp_valid", resp_valid_o, due);
            if (resp_valid_o && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_we", resp_we_o, e.we);
                chk("resp_rdata", resp_rdata_o, e.data);
                if (!e.we) chk("resp_rd", resp_rd_o, e.rd);
            end else if (due) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        r_v, r_we, r_uns, r_fl, r_g, r_rvl;
        bit [1:0]  r_sz;
        bit [31:0] r_addr;
        do_reset();

        req(0, 2, 0, 32'h100, 0, 5);
        gnt();
        idle(1);
        rv(32'hDEADBEEF);
        idle(2);

        req(0, 0, 0, 32'h103, 0, 7);
        gnt();
        rv(32'h80FFFFFF);
        req(0, 0, 1, 32'h103, 0, 8);
        gnt();
        rv(32'h80FFFFFF);
        idle(2);

        req(1, 1, 0, 32'h102, 32'h1234, 0);
        gnt();
        rv(32'h0);
        idle(2);

        req(0, 2, 0, 32'h200, 0, 1);
        idle(3);
        gnt();
        req(0, 1, 1, 32'h206, 0, 2);
        gnt();
        do_cycle(1, 0, 2, 0, 32'h300, 0, 3, 0, 0, 0, 0);
        do_cycle(1, 0, 2, 0, 32'h300, 0, 3, 0, 0, 1, 32'hCAFEF00D);
        req(0, 2, 0, 32'h300, 0, 3);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000FFFE);
        idle(1);
        rv(32'h12345678);
        rv(32'h87654321);
        idle(2);

        req(0, 2, 0, 32'h400, 0, 9);
        gnt();
        req(0, 2, 0, 32'h404, 0, 10);
        gnt();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rv(32'h11111111);
        rv(32'h22222222);
        idle(1);
        req(0, 2, 0, 32'h408, 0, 11);
        gnt();
        rv(32'h33333333);
        idle(2);

        req(0, 2, 0, 32'h102, 0, 4);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            r_v   = ($urandom % 2) == 0;
            r_we  = ($urandom % 2) == 0;
            r_sz  = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
            r_uns = ($urandom % 2) == 0;
            r_addr = $urandom;
            if (($urandom % 4) != 0) r_addr = r_addr & ~((32'd1 << r_sz) - 1);
            r_fl  = ($urandom % 25) == 0;
            r_g   = ($urandom % 2) == 0;
            r_rvl = (outst.size() != 0) && (($urandom % 3) == 0);
            do_cycle(r_v, r_we, r_sz, r_uns, r_addr, $urandom,
                     5'($urandom), r_fl, r_g, r_rvl, $urandom);
        end

        for (int i = 0; i < 50 && (apend.size() + outst.size()) != 0; i++)
            do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, outst.size() != 0, $urandom);
        idle(2);

        rv(32'hFFFFFFFF);
        idle(3);
        req(0, 2, 0, 32'h500, 0, 12);
        gnt();
        rv(32'h0BADF00D);
        idle(2);
        do_reset();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
